note_sequencer: RTL and testbench

//   Parametrised note recorder/player; successor to the fixed control/datapath note-counter pair.

---
 rtl/note_sequencer.sv | 169 ++++++++++++++++
 tb/tb_note_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// Note recorder/player: records up to DEPTH (note, octave) events, then plays them back
// with a fixed note length, an inter-note gap, optional looping and rest slots.
module note_sequencer #(
   parameter int DEPTH          = 16,
   parameter int PTR_W          = 4,
   parameter int CNT_W          = 24,
   parameter int TICKS_PER_NOTE = 12_500_000,
   parameter int GAP_TICKS      = 1_250_000
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   input  logic             ld_note,
   input  logic [3:0]       note_in,
   input  logic [1:0]       octave_in,
   input  logic             play,
   input  logic             stop,
   input  logic             clear,
   input  logic             loop_en,
   output logic [3:0]       note_out,
   output logic [1:0]       octave_out,
   output logic             note_valid,
   output logic             playing,
   output logic [PTR_W-1:0] note_index,
   output logic [PTR_W:0]   note_count,
   output logic             full,
   output logic             empty
);

   localparam logic [1:0]       ST_IDLE   = 2'd0;
   localparam logic [1:0]       ST_PLAY   = 2'd1;
   localparam logic [1:0]       ST_GAP    = 2'd2;
   localparam logic [3:0]       REST      = 4'hF;
   localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(TICKS_PER_NOTE - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

   logic [5:0]       mem [DEPTH];
   logic [1:0]       state_q,  state_d;
   logic [CNT_W-1:0] tick_q,   tick_d;
   logic [PTR_W:0]   count_q,  count_d;
   logic [PTR_W-1:0] index_q,  index_d;
   logic [3:0]       note_q,   note_d;
   logic [1:0]       octave_q, octave_d;
   logic             valid_q,  valid_d;

   logic             wr_en, slot_end, last_slot;
   logic [PTR_W-1:0] next_idx;
   logic [5:0]       rd_first, rd_next;

   assign last_slot = ({1'b0, index_q} + (PTR_W+1)'(1)) >= count_q;
   assign next_idx  = last_slot ? '0 : index_q + PTR_W'(1);
   assign rd_first  = mem[0];
   assign rd_next   = mem[next_idx];

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d  = state_q;
      tick_d   = tick_q;
      count_d  = count_q;
      index_d  = index_q;
      note_d   = note_q;
      octave_d = octave_q;
      valid_d  = valid_q;
      wr_en    = 1'b0;
      slot_end = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!clear && !stop) begin
               if (play) begin
                  if (!empty) begin
                     state_d  = ST_PLAY;
                     tick_d   = '0;
                     index_d  = '0;
                     note_d   = rd_first[5:2];
                     octave_d = rd_first[1:0];
                     valid_d  = (rd_first[5:2] != REST);
                  end
               end else if (ld_note && !full) begin
                  wr_en   = 1'b1;
                  count_d = count_q + (PTR_W+1)'(1);
               end
            end
         end
         ST_PLAY: begin
            if (tick_q == NOTE_LAST) begin
               if (GAP_TICKS == 0) begin
                  slot_end = 1'b1;
               end else begin
                  state_d = ST_GAP;
                  tick_d  = '0;
                  valid_d = 1'b0;
               end
            end else begin
               tick_d = tick_q + CNT_W'(1);
            end
         end
         ST_GAP: begin
            if (tick_q == GAP_LAST) slot_end = 1'b1;
            else                    tick_d   = tick_q + CNT_W'(1);
         end
         default: state_d = ST_IDLE;
      endcase

      // End of slot: advance, wrap when looping, or fall back to idle after the last slot.
      if (slot_end) begin
         tick_d = '0;
         if (last_slot && !loop_en) begin
            state_d  = ST_IDLE;
            index_d  = '0;
            note_d   = '0;
            octave_d = '0;
            valid_d  = 1'b0;
         end else begin
            state_d  = ST_PLAY;
            index_d  = next_idx;
            note_d   = rd_next[5:2];
            octave_d = rd_next[1:0];
            valid_d  = (rd_next[5:2] != REST);
         end
      end

      if (state_q != ST_IDLE && (stop || clear)) begin
         state_d  = ST_IDLE;
         tick_d   = '0;
         index_d  = '0;
         note_d   = '0;
         octave_d = '0;
         valid_d  = 1'b0;
      end

      if (clear) count_d = '0;
   end

   always_ff @(posedge CLOCK_50) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state_q  <= ST_IDLE;
         tick_q   <= '0;
         count_q  <= '0;
         index_q  <= '0;
         note_q   <= '0;
         octave_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         tick_q   <= tick_d;
         count_q  <= count_d;
         index_q  <= index_d;
         note_q   <= note_d;
         octave_q <= octave_d;
         valid_q  <= valid_d;
      end
   end

   // NOTE: the note memory is deliberately not reset; note_count alone says which slots are valid.
   always_ff @(posedge CLOCK_50) begin
      if (wr_en) mem[count_q[PTR_W-1:0]] <= {note_in, octave_in};
   end

   assign note_out   = note_q;
   assign octave_out = octave_q;
   assign note_valid = valid_q;
   assign playing    = (state_q != ST_IDLE);
   assign note_index = index_q;
   assign note_count = count_q;
   assign empty      = (count_q == '0);
   assign full       = (count_q == (PTR_W+1)'(DEPTH));

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with DEPTH=4, TICKS_PER_NOTE=4, GAP_TICKS=2 (slot = 6 cycles).
module tb_note_sequencer;

   localparam int DEPTH = 4;
   localparam int PTR_W = 2;
   localparam int CNT_W = 24;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             ld_note = 1'b0;
   logic [3:0]       note_in = '0;
   logic [1:0]       octave_in = '0;
   logic             play = 1'b0;
   logic             stop = 1'b0;
   logic             clear = 1'b0;
   logic             loop_en = 1'b0;
   logic [3:0]       note_out;
   logic [1:0]       octave_out;
   logic             note_valid;
   logic             playing;
   logic [PTR_W-1:0] note_index;
   logic [PTR_W:0]   note_count;
   logic             full;
   logic             empty;

   int checks = 0;
   int errors = 0;

   note_sequencer #(
      .DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W),
      .TICKS_PER_NOTE(4), .GAP_TICKS(2)
   ) dut (
      .CLOCK_50(clk), .reset(reset), .ld_note(ld_note), .note_in(note_in),
      .octave_in(octave_in), .play(play), .stop(stop), .clear(clear),
      .loop_en(loop_en), .note_out(note_out), .octave_out(octave_out),
      .note_valid(note_valid), .playing(playing), .note_index(note_index),
      .note_count(note_count), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic record(input logic [3:0] n, input logic [1:0] o);
      ld_note = 1'b1; note_in = n; octave_in = o;
      step(1);
      ld_note = 1'b0;
   endtask

   task automatic pulse_play();
      play = 1'b1; step(1); play = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1; step(1); clear = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_playing"}, 32'(playing), 32'd0);
      check({tag, "_valid"},   32'(note_valid), 32'd0);
      check({tag, "_note"},    32'(note_out), 32'd0);
      check({tag, "_octave"},  32'(octave_out), 32'd0);
      check({tag, "_index"},   32'(note_index), 32'd0);
   endtask

   logic [3:0] t1_notes [3];
   logic [1:0] t1_oct   [3];
   logic [3:0] t4_notes [3];
   logic       t4_valid [3];

   initial begin
      t1_notes[0] = 4'd1;  t1_oct[0] = 2'd0;
      t1_notes[1] = 4'd5;  t1_oct[1] = 2'd1;
      t1_notes[2] = 4'd11; t1_oct[2] = 2'd3;
      t4_notes[0] = 4'd3;  t4_valid[0] = 1'b1;
      t4_notes[1] = 4'hF;  t4_valid[1] = 1'b0;
      t4_notes[2] = 4'd7;  t4_valid[2] = 1'b1;

      // Reset state
      #1;
      step(2);
      reset = 1'b0;
      check_idle("rst");
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full",  32'(full),  32'd0);
      check("rst_count", 32'(note_count), 32'd0);

      // 1: record three notes and play them once
      for (int i = 0; i < 3; i++) record(t1_notes[i], t1_oct[i]);
      check("t1_count", 32'(note_count), 32'd3);
      check("t1_empty", 32'(empty), 32'd0);
      pulse_play();
      for (int k = 0; k < 18; k++) begin
         check($sformatf("t1_playing_k%0d", k), 32'(playing), 32'd1);
         check($sformatf("t1_valid_k%0d", k), 32'(note_valid), 32'((k % 6) < 4));
         check($sformatf("t1_index_k%0d", k), 32'(note_index), 32'(k / 6));
         if ((k % 6) < 4) begin
            check($sformatf("t1_note_k%0d", k), 32'(note_out), 32'(t1_notes[k / 6]));
            check($sformatf("t1_oct_k%0d", k), 32'(octave_out), 32'(t1_oct[k / 6]));
         end
         step(1);
      end
      check_idle("t1_end");
      check("t1_end_count", 32'(note_count), 32'd3);

      // 2: overfill a four-slot memory
      pulse_clear();
      check("t2_clr_empty", 32'(empty), 32'd1);
      check("t2_clr_count", 32'(note_count), 32'd0);
      record(4'd2, 2'd0);
      record(4'd4, 2'd1);
      record(4'd6, 2'd2);
      check("t2_full_3", 32'(full), 32'd0);
      record(4'd8, 2'd3);
      check("t2_full_4", 32'(full), 32'd1);
      check("t2_count_4", 32'(note_count), 32'd4);
      record(4'd9, 2'd1);
      check("t2_count_5", 32'(note_count), 32'd4);
      check("t2_full_5", 32'(full), 32'd1);
      pulse_play();
      check("t2_slot0_note", 32'(note_out), 32'd2);
      check("t2_slot0_oct", 32'(octave_out), 32'd0);
      step(18);
      check("t2_slot3_index", 32'(note_index), 32'd3);
      check("t2_slot3_note", 32'(note_out), 32'd8);
      check("t2_slot3_oct", 32'(octave_out), 32'd3);
      stop = 1'b1; step(1); stop = 1'b0;
      check_idle("t2_stop");
      check("t2_stop_count", 32'(note_count), 32'd4);

      // 3: looping over two notes, then stop mid-PLAY
      pulse_clear();
      record(4'd1, 2'd1);
      record(4'd2, 2'd2);
      loop_en = 1'b1;
      pulse_play();
      for (int s = 0; s < 4; s++) begin
         check($sformatf("t3_index_s%0d", s), 32'(note_index), 32'(s % 2));
         check($sformatf("t3_note_s%0d", s), 32'(note_out), 32'((s % 2) + 1));
         check($sformatf("t3_valid_s%0d", s), 32'(note_valid), 32'd1);
         step(6);
      end
      check("t3_wrap_index", 32'(note_index), 32'd0);
      step(1);
      stop = 1'b1; step(1); stop = 1'b0;
      check_idle("t3_stop");
      check("t3_stop_count", 32'(note_count), 32'd2);
      loop_en = 1'b0;

      // 4: rest slot in the middle
      pulse_clear();
      record(4'd3, 2'd2);
      record(4'hF, 2'd0);
      record(4'd7, 2'd1);
      pulse_play();
      check("t4_oct0", 32'(octave_out), 32'd2);
      for (int s = 0; s < 3; s++) begin
         check($sformatf("t4_note_s%0d", s), 32'(note_out), 32'(t4_notes[s]));
         check($sformatf("t4_valid_s%0d", s), 32'(note_valid), 32'(t4_valid[s]));
         step(3);
         check($sformatf("t4_valid_mid_s%0d", s), 32'(note_valid), 32'(t4_valid[s]));
         check($sformatf("t4_play_mid_s%0d", s), 32'(playing), 32'd1);
         step(2);
         check($sformatf("t4_gap_valid_s%0d", s), 32'(note_valid), 32'd0);
         check($sformatf("t4_gap_play_s%0d", s), 32'(playing), 32'd1);
         step(1);
      end
      check_idle("t4_end");

      // 5: play while empty, clear during GAP, play+ld_note together
      pulse_clear();
      pulse_play();
      check("t5_empty_play", 32'(playing), 32'd0);
      check("t5_empty_count", 32'(note_count), 32'd0);
      record(4'd1, 2'd0);
      record(4'd2, 2'd0);
      pulse_play();
      step(4);
      check("t5_in_gap_valid", 32'(note_valid), 32'd0);
      check("t5_in_gap_play", 32'(playing), 32'd1);
      pulse_clear();
      check_idle("t5_clr");
      check("t5_clr_count", 32'(note_count), 32'd0);
      check("t5_clr_empty", 32'(empty), 32'd1);
      record(4'd5, 2'd1);
      play = 1'b1; ld_note = 1'b1; note_in = 4'd6; octave_in = 2'd2;
      step(1);
      play = 1'b0; ld_note = 1'b0;
      check("t5_both_play", 32'(playing), 32'd1);
      check("t5_both_count", 32'(note_count), 32'd1);
      check("t5_both_note", 32'(note_out), 32'd5);

      // 6: reset mid-PLAY, then play is ignored on the emptied recorder
      step(1);
      reset = 1'b1; step(1); reset = 1'b0;
      check_idle("t6_rst");
      check("t6_empty", 32'(empty), 32'd1);
      check("t6_full", 32'(full), 32'd0);
      pulse_play();
      check("t6_play_ignored", 32'(playing), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
